// File: rtl/nonce_result_scanner_pkg.sv
`default_nettype none
// ============================================================================
// nonce_result_scanner_pkg : shared constants, FSM encoding and report packing
// Rev 1.0
// ============================================================================
package nonce_result_scanner_pkg;

    localparam int NUM_NONCES_DEFAULT = 16;
    localparam int REPORT_WORDS       = 2;

    localparam int FOUND_BIT       = 31;
    localparam int MIN_NONCE_LSB   = 8;
    localparam int FOUND_NONCE_LSB = 0;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_PRIME = 3'd1;
    localparam logic [2:0] ST_SCAN  = 3'd2;
    localparam logic [2:0] ST_WR0   = 3'd3;
    localparam logic [2:0] ST_WR1   = 3'd4;

    function automatic logic [31:0] pack_report(input logic       found,
                                                input logic [7:0] min_nonce,
                                                input logic [7:0] found_nonce);
        logic [31:0] w;
        w                          = '0;
        w[FOUND_BIT]               = found;
        w[MIN_NONCE_LSB +: 8]      = min_nonce;
        w[FOUND_NONCE_LSB +: 8]    = found_nonce;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nonce_result_scanner_if.sv
`default_nettype none
// ============================================================================
// nonce_result_scanner_if : single-port memory bus shared with the hash engine
// Rev 1.0
// ============================================================================
interface nonce_result_scanner_if;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport master (
        output mem_clk,
        output mem_we,
        output mem_addr,
        output mem_write_data,
        input  mem_read_data
    );

    modport slave (
        input  mem_clk,
        input  mem_we,
        input  mem_addr,
        input  mem_write_data,
        output mem_read_data
    );
endinterface
`default_nettype wire

// File: rtl/nonce_result_scanner_hash_min_tracker.sv
`default_nettype none
// ============================================================================
// hash_min_tracker : next-state of first-passing nonce and minimum hash
// Rev 1.0
// ============================================================================
module hash_min_tracker
    import nonce_result_scanner_pkg::*;
(
    input  wire logic [31:0] data_i,
    input  wire logic [31:0] target_i,
    input  wire logic [7:0]  idx_i,
    input  wire logic        found_i,
    input  wire logic [7:0]  found_nonce_i,
    input  wire logic [31:0] min_hash_i,
    input  wire logic [7:0]  min_nonce_i,
    output logic             found_o,
    output logic [7:0]       found_nonce_o,
    output logic [31:0]      min_hash_o,
    output logic [7:0]       min_nonce_o
);

    // Strict compares: the earliest index keeps both the found slot and min ties.
    always_comb begin
        found_o       = found_i;
        found_nonce_o = found_nonce_i;
        min_hash_o    = min_hash_i;
        min_nonce_o   = min_nonce_i;
        if (!found_i && (data_i < target_i)) begin
            found_o       = 1'b1;
            found_nonce_o = idx_i;
        end
        if (data_i < min_hash_i) begin
            min_hash_o  = data_i;
            min_nonce_o = idx_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// nonce_result_scanner : reads back per-nonce H0 words, finds first pass/min
// Rev 1.0
// ============================================================================
module nonce_result_scanner
    import nonce_result_scanner_pkg::*;
#(
    parameter int NUM_NONCES = NUM_NONCES_DEFAULT
)(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        start_i,
    input  wire logic [15:0] hash_addr_i,
    input  wire logic [15:0] report_addr_i,
    input  wire logic [31:0] target_i,
    output logic             done_o,
    output logic             found_o,
    output logic [7:0]       found_nonce_o,
    output logic [31:0]      min_hash_o,
    output logic [7:0]       min_nonce_o,
    nonce_result_scanner_if.master mem
);

    localparam logic [15:0] c_LAST_REPORT_OFS = 16'(REPORT_WORDS - 1);

    logic [2:0]  state_q, state_d;
    logic        done_q, done_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] report_addr_q, report_addr_d;
    logic [31:0] target_q, target_d;
    logic        found_q, found_d;
    logic [7:0]  found_nonce_q, found_nonce_d;
    logic [31:0] min_hash_q, min_hash_d;
    logic [7:0]  min_nonce_q, min_nonce_d;

    logic        trk_found;
    logic [7:0]  trk_found_nonce;
    logic [31:0] trk_min_hash;
    logic [7:0]  trk_min_nonce;

    hash_min_tracker u_tracker (
        .data_i        (mem.mem_read_data),
        .target_i      (target_q),
        .idx_i         (idx_q),
        .found_i       (found_q),
        .found_nonce_i (found_nonce_q),
        .min_hash_i    (min_hash_q),
        .min_nonce_i   (min_nonce_q),
        .found_o       (trk_found),
        .found_nonce_o (trk_found_nonce),
        .min_hash_o    (trk_min_hash),
        .min_nonce_o   (trk_min_nonce)
    );

    always_comb begin
        state_d       = state_q;
        done_d        = done_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rd_ptr_d      = rd_ptr_q;
        idx_d         = idx_q;
        report_addr_d = report_addr_q;
        target_d      = target_q;
        found_d       = found_q;
        found_nonce_d = found_nonce_q;
        min_hash_d    = min_hash_q;
        min_nonce_d   = min_nonce_q;
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b1;
                if (start_i) begin
                    report_addr_d = report_addr_i;
                    target_d      = target_i;
                    addr_d        = hash_addr_i;
                    rd_ptr_d      = hash_addr_i + 16'd1;
                    done_d        = 1'b0;
                    found_d       = 1'b0;
                    found_nonce_d = 8'd0;
                    min_nonce_d   = 8'd0;
                    min_hash_d    = 32'hFFFF_FFFF;
                    idx_d         = 8'd0;
                    state_d       = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (NUM_NONCES > 1) begin
                    addr_d   = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + 16'd1;
                end
                state_d = ST_SCAN;
            end
            ST_SCAN: begin
                found_d       = trk_found;
                found_nonce_d = trk_found_nonce;
                min_hash_d    = trk_min_hash;
                min_nonce_d   = trk_min_nonce;
                // Reads run two words ahead of idx, so issuing stops two early.
                if (int'(idx_q) + 2 < NUM_NONCES) begin
                    addr_d   = rd_ptr_q;
                    rd_ptr_d = rd_ptr_q + 16'd1;
                end
                idx_d = idx_q + 8'd1;
                if (int'(idx_q) == NUM_NONCES - 1) begin
                    state_d = ST_WR0;
                end
            end
            ST_WR0: begin
                we_d    = 1'b1;
                addr_d  = report_addr_q;
                wdata_d = min_hash_q;
                state_d = ST_WR1;
            end
            ST_WR1: begin
                we_d    = 1'b1;
                addr_d  = report_addr_q + c_LAST_REPORT_OFS;
                wdata_d = pack_report(found_q, min_nonce_q, found_nonce_q);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            done_q        <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= 16'd0;
            wdata_q       <= 32'd0;
            rd_ptr_q      <= 16'd0;
            idx_q         <= 8'd0;
            report_addr_q <= 16'd0;
            target_q      <= 32'd0;
            found_q       <= 1'b0;
            found_nonce_q <= 8'd0;
            min_hash_q    <= 32'hFFFF_FFFF;
            min_nonce_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            done_q        <= done_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rd_ptr_q      <= rd_ptr_d;
            idx_q         <= idx_d;
            report_addr_q <= report_addr_d;
            target_q      <= target_d;
            found_q       <= found_d;
            found_nonce_q <= found_nonce_d;
            min_hash_q    <= min_hash_d;
            min_nonce_q   <= min_nonce_d;
        end
    end

    assign done_o             = done_q;
    assign found_o            = found_q;
    assign found_nonce_o      = found_nonce_q;
    assign min_hash_o         = min_hash_q;
    assign min_nonce_o        = min_nonce_q;
    assign mem.mem_clk        = clk;
    assign mem.mem_we         = we_q;
    assign mem.mem_addr       = addr_q;
    assign mem.mem_write_data = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_nonce_result_scanner.sv
`default_nettype none
// ============================================================================
// tb_nonce_result_scanner : directed + random runs against a reference model
// Rev 1.0
// ============================================================================
module tb_nonce_result_scanner;

    localparam int N = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, start1;
    logic [15:0] hash_addr, report_addr;
    logic [31:0] target;

    logic        done0, found0, done1, found1;
    logic [7:0]  fn0, mn0, fn1, mn1;
    logic [31:0] mh0, mh1;

    nonce_result_scanner_if bus0();
    nonce_result_scanner_if bus1();

    nonce_result_scanner #(.NUM_NONCES(N)) dut0 (
        .clk(clk), .reset(reset), .start_i(start0),
        .hash_addr_i(hash_addr), .report_addr_i(report_addr), .target_i(target),
        .done_o(done0), .found_o(found0), .found_nonce_o(fn0),
        .min_hash_o(mh0), .min_nonce_o(mn0), .mem(bus0.master)
    );

    nonce_result_scanner #(.NUM_NONCES(1)) dut1 (
        .clk(clk), .reset(reset), .start_i(start1),
        .hash_addr_i(hash_addr), .report_addr_i(report_addr), .target_i(target),
        .done_o(done1), .found_o(found1), .found_nonce_o(fn1),
        .min_hash_o(mh1), .min_nonce_o(mn1), .mem(bus1.master)
    );

    // Memories with one registered read stage: address on edge k, data seen on k+2.
    logic [31:0] mem0 [0:65535];
    logic [31:0] mem1 [0:65535];
    int wr0 = 0;
    int wr1 = 0;

    always @(posedge clk) begin
        if (bus0.mem_we) begin
            mem0[bus0.mem_addr] = bus0.mem_write_data;
            wr0 = wr0 + 1;
        end
        bus0.mem_read_data <= mem0[bus0.mem_addr];
    end

    always @(posedge clk) begin
        if (bus1.mem_we) begin
            mem1[bus1.mem_addr] = bus1.mem_write_data;
            wr1 = wr1 + 1;
        end
        bus1.mem_read_data <= mem1[bus1.mem_addr];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    logic [31:0] words [N];

    // First passing index and minimum value (lowest index on ties) over n words.
    task automatic model(input int n, input logic [31:0] tgt,
                         output logic f, output logic [7:0] fn,
                         output logic [31:0] mh, output logic [7:0] mn);
        logic [31:0] best;
        int          first_pass;
        int          best_idx;
        first_pass = -1;
        best       = 32'hFFFF_FFFF;
        best_idx   = 0;
        for (int i = 0; i < n; i++) begin
            if (first_pass < 0 && words[i] < tgt) first_pass = i;
            if (words[i] < best) begin
                best     = words[i];
                best_idx = i;
            end
        end
        f  = (first_pass >= 0);
        fn = (first_pass >= 0) ? 8'(first_pass) : 8'd0;
        mh = best;
        mn = 8'(best_idx);
    endtask

    task automatic run0(input string tag, input logic [15:0] ha, input logic [15:0] ra,
                        input logic [31:0] tg, input bit mid_start);
        logic        f;
        logic [7:0]  fn, mn;
        logic [31:0] mh;
        int          cyc;
        int          wbase;
        mem0[ra]           = 32'hDEAD_BEEF;
        mem0[16'(ra + 1)]  = 32'hDEAD_BEEF;
        for (int i = 0; i < N; i++) mem0[16'(ha + i)] = words[i];
        wbase = wr0;
        @(negedge clk);
        hash_addr   = ha;
        report_addr = ra;
        target      = tg;
        start0      = 1'b1;
        @(posedge clk);
        #1;
        start0      = 1'b0;
        hash_addr   = 16'($urandom);
        report_addr = 16'($urandom);
        target      = $urandom;
        check({tag, ":busy"}, {31'd0, done0}, 32'd0);
        cyc = 0;
        while (cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            start0 = (mid_start && cyc == 5) ? 1'b1 : 1'b0;
            if (done0) break;
        end
        start0 = 1'b0;
        model(N, tg, f, fn, mh, mn);
        check({tag, ":latency"},     32'(cyc),            32'(N + 4));
        check({tag, ":found"},       {31'd0, found0},     {31'd0, f});
        check({tag, ":found_nonce"}, {24'd0, fn0},        {24'd0, fn});
        check({tag, ":min_hash"},    mh0,                 mh);
        check({tag, ":min_nonce"},   {24'd0, mn0},        {24'd0, mn});
        check({tag, ":report0"},     mem0[ra],            mh);
        check({tag, ":report1"},     mem0[16'(ra + 1)],   {f, 15'd0, mn, fn});
        check({tag, ":writes"},      32'(wr0 - wbase),    32'd2);
        @(posedge clk);
        #1;
        check({tag, ":we_idle"},     {31'd0, bus0.mem_we}, 32'd0);
        check({tag, ":hold"},        mh0,                 mh);
    endtask

    initial begin
        logic        f;
        logic [7:0]  fn, mn;
        logic [31:0] mh;
        int          cyc;
        bit          seen;
        logic [31:0] tgts [4];

        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 32'd0;
            mem1[a] = 32'd0;
        end
        reset = 1'b1; start0 = 1'b0; start1 = 1'b0;
        hash_addr = '0; report_addr = '0; target = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst:done",        {31'd0, done0},        32'd1);
        check("rst:we",          {31'd0, bus0.mem_we},  32'd0);
        check("rst:addr",        {16'd0, bus0.mem_addr}, 32'd0);
        check("rst:wdata",       bus0.mem_write_data,   32'd0);
        check("rst:found",       {31'd0, found0},       32'd0);
        check("rst:found_nonce", {24'd0, fn0},          32'd0);
        check("rst:min_hash",    mh0,                   32'hFFFF_FFFF);
        check("rst:min_nonce",   {24'd0, mn0},          32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N; i++) words[i] = 32'h100 - 32'(i);
        run0("descend", 16'h1000, 16'h2000, 32'h0000_00F6, 1'b0);

        for (int i = 0; i < N; i++) words[i] = 32'h8000_0000;
        run0("ties", 16'h3000, 16'h3100, 32'h8000_0000, 1'b0);

        for (int i = 0; i < N; i++) words[i] = $urandom;
        run0("wrap", 16'hFFFE, 16'hFFFF, $urandom, 1'b0);

        for (int i = 0; i < N; i++) words[i] = $urandom;
        run0("midstart", 16'h4000, 16'h4100, $urandom, 1'b1);

        // Asynchronous reset in the middle of the scan.
        @(negedge clk);
        hash_addr = 16'h5000; report_addr = 16'h5100; target = 32'hFFFF_FFFF;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_scan:done",     {31'd0, done0},       32'd1);
        check("rst_scan:we",       {31'd0, bus0.mem_we}, 32'd0);
        check("rst_scan:min_hash", mh0,                  32'hFFFF_FFFF);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) words[i] = $urandom_range(0, 5000);
        run0("after_rst", 16'h5000, 16'h5100, 32'd2500, 1'b0);

        // Asynchronous reset while a report write is on the bus.
        @(negedge clk);
        hash_addr = 16'h6000; report_addr = 16'h6100; target = 32'd7;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 60 && !seen) begin
            @(posedge clk);
            #1;
            cyc++;
            seen = bus0.mem_we;
        end
        check("rst_wr:seen_we", {31'd0, seen}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_wr:we",   {31'd0, bus0.mem_we}, 32'd0);
        check("rst_wr:done", {31'd0, done0},       32'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < N; i++) words[i] = 32'hFFFF_FFFF;
        run0("all_ones", 16'h7000, 16'h7100, 32'hFFFF_FFFF, 1'b0);

        tgts[0] = 32'd0;
        tgts[1] = 32'hFFFF_FFFF;
        tgts[2] = 32'd500;
        tgts[3] = $urandom;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 3))
                    0:       words[i] = 32'hFFFF_FFFF;
                    1:       words[i] = $urandom_range(0, 1000);
                    default: words[i] = $urandom;
                endcase
            end
            run0($sformatf("rand%0d", r), 16'(16'h8000 + r * 64), 16'(16'h9000 + r * 4),
                 tgts[r], 1'b0);
        end

        // Single-nonce instance.
        words[0]      = 32'h5;
        mem1[16'h40]  = 32'h5;
        mem1[16'h80]  = 32'hDEAD_BEEF;
        mem1[16'h81]  = 32'hDEAD_BEEF;
        @(negedge clk);
        hash_addr = 16'h40; report_addr = 16'h80; target = 32'h6;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        cyc = 0;
        while (cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done1) break;
        end
        model(1, 32'h6, f, fn, mh, mn);
        check("n1:latency",     32'(cyc),         32'd5);
        check("n1:found",       {31'd0, found1},  {31'd0, f});
        check("n1:found_nonce", {24'd0, fn1},     {24'd0, fn});
        check("n1:min_hash",    mh1,              mh);
        check("n1:min_nonce",   {24'd0, mn1},     {24'd0, mn});
        check("n1:report0",     mem1[16'h80],     32'h0000_0005);
        check("n1:report1",     mem1[16'h81],     32'h8000_0000);
        check("n1:writes",      32'(wr1),         32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
